prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Serial program loader: shifts LSB-first address/data frames into imem or dmem, then gates the core.
// Define LOADER_SYNC_EN for a 2-flop synchronizer input stage (default: single register stage).
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic [1:0]        mode_in,
    input  logic              halt_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              run_out,
    output logic              done_out,
    output logic              frame_err
);

    localparam int F  = ADDR_W + DATA_W;
    localparam int CW = $clog2(F + 1);
    localparam logic [CW-1:0] F_CNT = CW'(F);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT,
        S_RUN
    } state_t;

    logic       sclk_s;
    logic       mosi_s;
    logic [1:0] mode_s;

`ifdef LOADER_SYNC_EN
    logic [1:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic [3:0] mode_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            mode_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_in};
            mosi_sync_q <= {mosi_sync_q[0], mosi_in};
            mode_sync_q <= {mode_sync_q[1:0], mode_in};
        end
    end

    assign sclk_s = sclk_sync_q[1];
    assign mosi_s = mosi_sync_q[1];
    assign mode_s = mode_sync_q[3:2];
`else
    logic       sclk_in_q;
    logic       mosi_in_q;
    logic [1:0] mode_in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_in_q <= 1'b0;
            mosi_in_q <= 1'b0;
            mode_in_q <= 2'b00;
        end else begin
            sclk_in_q <= sclk_in;
            mosi_in_q <= mosi_in;
            mode_in_q <= mode_in;
        end
    end

    assign sclk_s = sclk_in_q;
    assign mosi_s = mosi_in_q;
    assign mode_s = mode_in_q;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            ovf_q, ovf_d;
    logic [F-1:0]    shreg_q, shreg_d;
    logic            tgt_q, tgt_d;
    logic            last_tgt_q, last_tgt_d;
    logic            done_q, done_d;
    logic            sclk_prev_q;
    logic            imem_we_q, imem_we_d;
    logic            dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic            run_q, run_d;
    logic            ferr_q, ferr_d;
    logic            sclk_rise;

    assign sclk_rise = sclk_s & ~sclk_prev_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ovf_d      = ovf_q;
        shreg_d    = shreg_q;
        tgt_d      = tgt_q;
        last_tgt_d = last_tgt_q;
        done_d     = done_q;
        imem_we_d  = 1'b0;
        dmem_we_d  = 1'b0;
        addr_d     = '0;
        wdata_d    = '0;
        run_d      = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                ovf_d     = 1'b0;
                if (mode_s == 2'b01 || mode_s == 2'b10) begin
                    state_d = S_SHIFT;
                    tgt_d   = mode_s[1];
                    if (mode_s[1] != last_tgt_q) begin
                        done_d = 1'b0;
                    end
                end else if (mode_s == 2'b11) begin
                    state_d = S_RUN;
                    run_d   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (mode_s == 2'b00) begin
                    if (bit_cnt_q == F_CNT && !ovf_q) begin
                        state_d   = S_COMMIT;
                        imem_we_d = ~tgt_q;
                        dmem_we_d = tgt_q;
                        addr_d    = shreg_q[ADDR_W-1:0];
                        wdata_d   = shreg_q[F-1:ADDR_W];
                    end else begin
                        state_d   = S_IDLE;
                        ferr_d    = 1'b1;
                        bit_cnt_d = '0;
                        ovf_d     = 1'b0;
                    end
                end else if (mode_s != {tgt_q, ~tgt_q}) begin
                    // Abort; IDLE picks up the new mode on the next cycle
                    state_d   = S_IDLE;
                    ferr_d    = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    ovf_d     = 1'b0;
                end else if (sclk_rise) begin
                    if (bit_cnt_q == F_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        shreg_d[bit_cnt_q] = mosi_s;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                state_d    = S_IDLE;
                bit_cnt_d  = '0;
                ovf_d      = 1'b0;
                last_tgt_d = tgt_q;
                if (&shreg_q[ADDR_W-1:0]) begin
                    done_d = 1'b1;
                end
            end
            S_RUN: begin
                if (mode_s == 2'b11) begin
                    run_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            shreg_q     <= '0;
            tgt_q       <= 1'b0;
            last_tgt_q  <= 1'b0;
            done_q      <= 1'b0;
            sclk_prev_q <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            run_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ovf_q       <= ovf_d;
            shreg_q     <= shreg_d;
            tgt_q       <= tgt_d;
            last_tgt_q  <= last_tgt_d;
            done_q      <= done_d;
            sclk_prev_q <= sclk_s;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            run_q       <= run_d;
            ferr_q      <= ferr_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_we_q ? addr_q : '0;
    assign imem_wdata = imem_we_q ? wdata_q : '0;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_we_q ? addr_q : '0;
    assign dmem_wdata = dmem_we_q ? wdata_q : '0;
    assign run_out    = run_q;
    assign done_out   = (state_q == S_RUN) ? halt_in : done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at frame end, popped on each we pulse.
module tb_prog_loader;

`ifdef LOADER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_in = 1'b0;
    logic       mosi_in = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic       halt_in = 1'b1;
    logic       imem_we, dmem_we, run_out, done_out, frame_err;
    logic [3:0] imem_addr, dmem_addr;
    logic [7:0] imem_wdata, dmem_wdata;

    prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_in), .mosi_in(mosi_in),
        .mode_in(mode_in), .halt_in(halt_in),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .run_out(run_out), .done_out(done_out), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dmem;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  fall_cyc = 0;
    int  fe_cnt = 0;
    int  fe_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (imem_we && dmem_we) chk("both_we", 1, 0);
        if (imem_we || dmem_we) begin
            if (sb.size() == 0) begin
                chk("unexp_we", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("we_port", {31'd0, dmem_we}, {31'd0, e.dmem});
                chk("addr", {28'd0, dmem_we ? dmem_addr : imem_addr}, {28'd0, e.addr});
                chk("data", {24'd0, dmem_we ? dmem_wdata : imem_wdata}, {24'd0, e.data});
                chk("lat", cyc - fall_cyc, LAT);
            end
        end
        if (!imem_we) chk("imem_idle", {20'd0, imem_addr, imem_wdata}, 0);
        if (!dmem_we) chk("dmem_idle", {20'd0, dmem_addr, dmem_wdata}, 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            mosi_in = v[i];
            sclk_in = 1'b0;
            clks(4);
            sclk_in = 1'b1;
            clks(4);
        end
        sclk_in = 1'b0;
        clks(4);
    endtask

    task automatic start_load(input logic d);
        mode_in = d ? 2'b10 : 2'b01;
        clks(4);
    endtask

    task automatic end_frame(input logic push, input logic d, input logic [3:0] a, input logic [7:0] v);
        wr_t e;
        e.dmem = d;
        e.addr = a;
        e.data = v;
        mode_in = 2'b00;
        fall_cyc = cyc;
        if (push) sb.push_back(e);
        clks(8);
    endtask

    task automatic frame(input logic d, input logic [3:0] a, input logic [7:0] v);
        start_load(d);
        send_bits({4'd0, v, a}, 12);
        end_frame(1'b1, d, a, v);
    endtask

    initial begin
        logic [26:0] outs;
        #1;
        outs = {imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
                run_out, done_out, frame_err};
        chk("rst_outs", {5'd0, outs}, 0);
        clks(3);
        chk("rst_done_halt", {31'd0, done_out}, 0);
        halt_in = 1'b0;
        rst = 1'b0;
        clks(3);

        // single imem write
        frame(1'b0, 4'd3, 8'hA5);
        chk("sb_a5", sb.size(), 0);
        chk("fe_a5", fe_cnt, fe_exp);

        // full imem load, done on addr 15
        for (int i = 0; i < 15; i++) frame(1'b0, 4'(i), 8'(i * 7 + 1));
        chk("done_pre15", {31'd0, done_out}, 0);
        frame(1'b0, 4'd15, 8'h6A);
        chk("done_imem", {31'd0, done_out}, 1);
        start_load(1'b1);
        chk("done_clr", {31'd0, done_out}, 0);
        send_bits({4'd0, 8'h11, 4'd0}, 12);
        end_frame(1'b1, 1'b1, 4'd0, 8'h11);
        for (int i = 1; i < 15; i++) frame(1'b1, 4'(i), 8'(i ^ 8'h5A));
        chk("done_pre15d", {31'd0, done_out}, 0);
        frame(1'b1, 4'd15, 8'hF0);
        chk("done_dmem", {31'd0, done_out}, 1);
        start_load(1'b1);
        chk("done_same", {31'd0, done_out}, 1);
        send_bits({4'd0, 8'h0F, 4'd15}, 12);
        end_frame(1'b1, 1'b1, 4'd15, 8'h0F);
        chk("done_rewr", {31'd0, done_out}, 1);

        // short and long frames
        start_load(1'b1);
        send_bits(16'h0055, 7);
        end_frame(1'b0, 1'b1, 4'd0, 8'd0);
        fe_exp++;
        chk("fe_short", fe_cnt, fe_exp);
        start_load(1'b1);
        send_bits(16'h1FFF, 13);
        end_frame(1'b0, 1'b1, 4'd0, 8'd0);
        fe_exp++;
        chk("fe_long", fe_cnt, fe_exp);

        // abort by switching load target mid-frame
        start_load(1'b0);
        send_bits(16'h001F, 5);
        start_load(1'b1);
        fe_exp++;
        chk("fe_abort", fe_cnt, fe_exp);
        send_bits({4'd0, 8'hC3, 4'd6}, 12);
        end_frame(1'b1, 1'b1, 4'd6, 8'hC3);
        chk("fe_after", fe_cnt, fe_exp);

        // run mode
        mode_in = 2'b11;
        clks(4);
        chk("run_on", {31'd0, run_out}, 1);
        chk("run_done0", {31'd0, done_out}, 0);
        halt_in = 1'b1;
        #1;
        chk("run_done1", {31'd0, done_out}, 1);
        @(negedge clk);
        mode_in = 2'b00;
        clks(LAT - 1);
        chk("run_hold", {31'd0, run_out}, 1);
        clks(1);
        chk("run_off", {31'd0, run_out}, 0);
        clks(4);

        // reset mid-frame
        halt_in = 1'b1;
        start_load(1'b0);
        send_bits(16'h003F, 6);
        rst = 1'b1;
        #1;
        outs = {imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
                run_out, done_out, frame_err};
        chk("rst_mid", {5'd0, outs}, 0);
        mode_in = 2'b00;
        halt_in = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(3);
        chk("fe_rst", fe_cnt, fe_exp);
        frame(1'b0, 4'd9, 8'h3C);
        chk("done_after_rst", {31'd0, done_out}, 0);

        clks(10);
        chk("sb_empty", sb.size(), 0);
        chk("fe_final", fe_cnt, fe_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
